// File: rtl/qspi_psram_pkg.sv
// Shared types and constants for the quad-SPI PSRAM controller.
package qspi_psram_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_CMD,
        INIT_END,
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        END
    } state_t;

    localparam logic [7:0] CMD_QPI_EN   = 8'h35;
    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

    // Opcode sent in the two command slots of a burst.
    function automatic logic [7:0] burst_cmd(input logic is_write);
        return is_write ? CMD_QWRITE : CMD_QREAD;
    endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// Output shift register, ram_clk phase toggle and slot counter.
// Each slot is two clk cycles: phase 0 (ram_clk low, data updated) and
// phase 1 (ram_clk high). The register shifts at the end of phase 1.
module qspi_nibble_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        load_quad,
    input  logic        run,
    input  logic        restart,
    input  logic        wload,
    input  logic [7:0]  wdata,
    output logic        phase,
    output logic [7:0]  slot,
    output logic [3:0]  io_o
);

    logic [31:0] sr_reg;
    logic        quad_reg;
    logic        phase_reg;
    logic [7:0]  slot_reg;

    // Shift/phase/slot sequencing; everything returns to zero when not running
    // so ram_clk and the io lines are quiet while chip select is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg    <= '0;
            quad_reg  <= 1'b0;
            phase_reg <= 1'b0;
            slot_reg  <= '0;
        end else if (load) begin
            sr_reg    <= load_val;
            quad_reg  <= load_quad;
            phase_reg <= 1'b0;
            slot_reg  <= '0;
        end else if (run) begin
            if (!phase_reg) begin
                phase_reg <= 1'b1;
            end else begin
                phase_reg <= 1'b0;
                slot_reg  <= restart ? 8'd0 : slot_reg + 8'd1;
                if (wload)
                    sr_reg <= {wdata, 24'h0};
                else if (quad_reg)
                    sr_reg <= {sr_reg[27:0], 4'h0};
                else
                    sr_reg <= {sr_reg[30:0], 1'b0};
            end
        end else begin
            sr_reg    <= '0;
            quad_reg  <= 1'b0;
            phase_reg <= 1'b0;
            slot_reg  <= '0;
        end
    end

    assign phase = phase_reg;
    assign slot  = slot_reg;

    // Single-bit mode uses io0 only; quad mode presents the top nibble.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_io
            if (gi == 0) begin : g_io0
                assign io_o[gi] = quad_reg ? sr_reg[28] : sr_reg[31];
            end else begin : g_ioq
                assign io_o[gi] = quad_reg & sr_reg[28 + gi];
            end
        end
    endgenerate

endmodule

// File: rtl/qspi_psram_ctrl.sv
// Quad-SPI PSRAM controller: power-up wait, QPI enable, then streamed
// quad reads (0xEB) and quad writes (0x38) from a 24-bit start address.
module qspi_psram_ctrl
    import qspi_psram_pkg::*;
#(
    parameter int INIT_WAIT  = 3750,
    parameter int DUMMY_CLKS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [1:0]  bank,
    input  logic        stop,
    input  logic [7:0]  wdata,
    output logic        wdata_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        init_done,
    output logic        ram_csn,
    output logic        ram_clk,
    output logic [1:0]  ram_bank,
    input  logic [3:0]  ram_io_i,
    output logic [3:0]  ram_io_o,
    output logic [3:0]  ram_io_oe
);

    localparam int         CNT_W    = (INIT_WAIT < 4) ? 2 : $clog2(INIT_WAIT);
    localparam logic [7:0] HDR_LAST = 8'(2 + ADDR_NIBBLES - 1);
    localparam logic [7:0] DUM_LAST = 8'(DUMMY_CLKS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             we_reg;
    logic [3:0]       rx_hi_reg;

    logic        sh_load;
    logic [31:0] sh_load_val;
    logic        sh_quad;
    logic        sh_run;
    logic        sh_restart;
    logic        sh_ph;
    logic [7:0]  sh_slot;
    logic        hdr_last;
    logic        dummy_last;
    logic        data_boundary;

    qspi_nibble_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_val  (sh_load_val),
        .load_quad (sh_quad),
        .run       (sh_run),
        .restart   (sh_restart),
        .wload     (wdata_ready),
        .wdata     (wdata),
        .phase     (sh_ph),
        .slot      (sh_slot),
        .io_o      (ram_io_o)
    );

    assign ram_clk = sh_ph;
    assign busy    = (state_reg != IDLE);

    // Slot-boundary decode and shifter control; wdata_ready must react to
    // stop within the boundary cycle itself, so it is decoded here.
    always_comb begin
        sh_run        = state_reg inside {INIT_CMD, CMD, ADDR, DUMMY, RDATA, WDATA};
        hdr_last      = (state_reg == ADDR) && sh_ph && (sh_slot == HDR_LAST);
        dummy_last    = (state_reg == DUMMY) && sh_ph && (sh_slot == DUM_LAST);
        data_boundary = ((state_reg == RDATA) || (state_reg == WDATA)) && sh_ph && sh_slot[0];
        sh_restart    = hdr_last || dummy_last || data_boundary;
        wdata_ready   = (hdr_last && we_reg) || ((state_reg == WDATA) && data_boundary && !stop);
        sh_load       = 1'b0;
        sh_quad       = 1'b0;
        sh_load_val   = '0;
        if ((state_reg == qspi_psram_pkg::INIT_WAIT) && (cnt_reg == CNT_W'(INIT_WAIT - 1))) begin
            sh_load     = 1'b1;
            sh_load_val = {CMD_QPI_EN, 24'h0};
        end else if ((state_reg == IDLE) && start) begin
            sh_load     = 1'b1;
            sh_quad     = 1'b1;
            sh_load_val = {burst_cmd(we), addr};
        end
    end

    // Main sequencer: init, request acceptance, burst phases and teardown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= qspi_psram_pkg::INIT_WAIT;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            rx_hi_reg   <= 4'h0;
            ram_csn     <= 1'b1;
            ram_io_oe   <= 4'b0000;
            ram_bank    <= 2'b00;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state_reg)
                qspi_psram_pkg::INIT_WAIT: begin
                    if (cnt_reg == CNT_W'(INIT_WAIT - 1)) begin
                        cnt_reg   <= '0;
                        ram_csn   <= 1'b0;
                        ram_io_oe <= 4'b0001;
                        state_reg <= INIT_CMD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                INIT_CMD: begin
                    if (sh_ph && (sh_slot == 8'd7)) begin
                        ram_csn   <= 1'b1;
                        ram_io_oe <= 4'b0000;
                        state_reg <= INIT_END;
                    end
                end
                INIT_END: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        cnt_reg   <= '0;
                        init_done <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        we_reg    <= we;
                        ram_bank  <= bank;
                        ram_csn   <= 1'b0;
                        ram_io_oe <= 4'b1111;
                        state_reg <= CMD;
                    end
                end
                CMD: begin
                    if (sh_ph && (sh_slot == 8'd1))
                        state_reg <= ADDR;
                end
                ADDR: begin
                    if (hdr_last) begin
                        if (we_reg) begin
                            state_reg <= WDATA;
                        end else begin
                            ram_io_oe <= 4'b0000;
                            state_reg <= DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (dummy_last)
                        state_reg <= RDATA;
                end
                RDATA: begin
                    if (sh_ph) begin
                        if (!sh_slot[0]) begin
                            rx_hi_reg <= ram_io_i;
                        end else begin
                            rdata       <= {rx_hi_reg, ram_io_i};
                            rdata_valid <= 1'b1;
                            if (stop)
                                state_reg <= END;
                        end
                    end
                end
                WDATA: begin
                    if (data_boundary && stop) begin
                        ram_io_oe <= 4'b0000;
                        state_reg <= END;
                    end
                end
                END: begin
                    // One cycle of csn hold after the last ram_clk edge,
                    // then csn high for two cycles before returning to IDLE.
                    if (cnt_reg == CNT_W'(0)) begin
                        ram_csn <= 1'b1;
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (cnt_reg == CNT_W'(2)) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    ram_csn   <= 1'b1;
                    ram_io_oe <= 4'b0000;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Directed bench for qspi_psram_ctrl with a small behavioural PSRAM model.
module tb_qspi_psram_ctrl;

    localparam int INIT_WAIT  = 8;
    localparam int DUMMY_CLKS = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [1:0]  bank = 2'b00;
    logic        stop = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        busy;
    logic        init_done;
    logic        ram_csn;
    logic        ram_clk;
    logic [1:0]  ram_bank;
    logic [3:0]  ram_io_i;
    logic [3:0]  ram_io_o;
    logic [3:0]  ram_io_oe;

    always #5 clk = ~clk;

    qspi_psram_ctrl #(.INIT_WAIT(INIT_WAIT), .DUMMY_CLKS(DUMMY_CLKS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .we          (we),
        .addr        (addr),
        .bank        (bank),
        .stop        (stop),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .init_done   (init_done),
        .ram_csn     (ram_csn),
        .ram_clk     (ram_clk),
        .ram_bank    (ram_bank),
        .ram_io_i    (ram_io_i),
        .ram_io_o    (ram_io_o),
        .ram_io_oe   (ram_io_oe)
    );

    // PSRAM model: samples on ram_clk high, logs {oe, io}, decodes QPI enable,
    // command, address and data, and drives read nibbles for the DUT to sample.
    logic [7:0]  mem [256];
    logic [7:0]  nlog [$];
    int          m_slot;
    int          m_d;
    logic        m_qpi;
    logic [7:0]  m_sr;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [3:0]  m_hi;
    logic [7:0]  m_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_slot   = 0;
            m_qpi    = 1'b0;
            ram_io_i = 4'h0;
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[8'h56] = 8'hA5;
            mem[8'h20] = 8'h11;
            mem[8'h21] = 8'h22;
            mem[8'h22] = 8'h33;
        end else if (ram_csn) begin
            m_slot = 0;
        end else if (ram_clk) begin
            nlog.push_back({ram_io_oe, ram_io_o});
            if (!m_qpi) begin
                m_sr = {m_sr[6:0], ram_io_o[0]};
                if (m_slot == 7 && m_sr == 8'h35) m_qpi = 1'b1;
            end else if (m_slot < 2) begin
                m_cmd = {m_cmd[3:0], ram_io_o};
            end else if (m_slot < 8) begin
                m_addr = {m_addr[19:0], ram_io_o};
            end else if (m_cmd == 8'h38) begin
                m_d = m_slot - 8;
                if ((m_d % 2) == 0) m_hi = ram_io_o;
                else mem[m_addr[7:0] + 8'(m_d / 2)] = {m_hi, ram_io_o};
            end else if (m_cmd == 8'hEB && m_slot >= 8 + DUMMY_CLKS) begin
                m_d = m_slot - 8 - DUMMY_CLKS;
                m_byte = mem[m_addr[7:0] + 8'(m_d / 2)];
                ram_io_i = ((m_d % 2) == 0) ? m_byte[7:4] : m_byte[3:0];
            end
            m_slot++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset release is assumed to have just happened at #1 after a posedge.
    task automatic do_init(input bit poke);
        int k;
        int base;
        logic [7:0] qcmd;
        qcmd = 8'h35;
        base = nlog.size();
        k = 0;
        while (ram_csn === 1'b1 && k < 40) begin
            step();
            k++;
            start = (poke && k == 3);
        end
        start = 1'b0;
        chk("init_wait_len", k, 8);
        chk("init_oe", ram_io_oe, 4'b0001);
        k = 0;
        while (ram_csn === 1'b0 && k < 40) begin
            step();
            k++;
        end
        chk("init_cmd_len", k, 16);
        step();
        chk("init_done_a1", init_done, 1'b0);
        step();
        chk("init_done_a2", init_done, 1'b1);
        chk("init_busy", busy, 1'b0);
        chk("init_log_n", nlog.size() - base, 8);
        for (int i = 0; i < 8; i++)
            chk("init_bit", nlog[base + i], {4'b0001, 3'b000, qcmd[7 - i]});
        repeat (4) step();
        chk("init_no_stray_csn", ram_csn, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int nv;
        int v_cyc [4];
        logic [7:0] v_dat [4];
        logic [3:0] exp_rd [8];
        logic [3:0] exp_wr [12];
        exp_rd = '{4'hE, 4'hB, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        exp_wr = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hD, 4'hE, 4'hA, 4'hD};

        // Reset values, then init with a stray start during INIT_WAIT.
        repeat (3) step();
        chk("rst_csn", ram_csn, 1'b1);
        chk("rst_clk", ram_clk, 1'b0);
        chk("rst_io_o", ram_io_o, 4'h0);
        chk("rst_oe", ram_io_oe, 4'h0);
        chk("rst_bank", ram_bank, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rvalid", rdata_valid, 1'b0);
        chk("rst_wready", wdata_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_busy", busy, 1'b1);
        rst_n = 1'b1;
        do_init(1'b1);

        // Single-byte read at 0x123456.
        base = nlog.size();
        addr = 24'h123456; we = 1'b0; stop = 1'b1; bank = 2'b00; start = 1'b1;
        step(); start = 1'b0; k = 1;
        chk("rd1_csn_low", ram_csn, 1'b0);
        while (rdata_valid !== 1'b1 && k < 60) begin step(); k++; end
        chk("rd1_valid_cyc", k, 33);
        chk("rd1_data", rdata, 8'hA5);
        chk("rd1_csn_t33", ram_csn, 1'b0);
        step(); k++;
        chk("rd1_csn_t34", ram_csn, 1'b1);
        chk("rd1_valid_once", rdata_valid, 1'b0);
        while (busy === 1'b1 && k < 60) begin step(); k++; end
        chk("rd1_idle_cyc", k, 36);
        chk("rd1_log_n", nlog.size() - base, 16);
        for (int i = 0; i < 8; i++)
            chk("rd1_nibble", nlog[base + i], {4'b1111, exp_rd[i]});

        // Three-byte read burst with a stray start while in RDATA.
        base = nlog.size();
        addr = 24'h000020; stop = 1'b0; start = 1'b1;
        step(); start = 1'b0; k = 1; nv = 0;
        while (busy === 1'b1 && k < 100) begin
            if (rdata_valid === 1'b1 && nv < 4) begin v_cyc[nv] = k; v_dat[nv] = rdata; nv++; end
            step(); k++;
            if (k == 30) begin start = 1'b1; we = 1'b1; bank = 2'b01; end
            else start = 1'b0;
            if (k == 38) stop = 1'b1;
        end
        start = 1'b0; we = 1'b0; bank = 2'b00;
        chk("brst_count", nv, 3);
        chk("brst_cyc0", v_cyc[0], 33);
        chk("brst_cyc1", v_cyc[1], 37);
        chk("brst_cyc2", v_cyc[2], 41);
        chk("brst_dat0", v_dat[0], 8'h11);
        chk("brst_dat1", v_dat[1], 8'h22);
        chk("brst_dat2", v_dat[2], 8'h33);
        chk("brst_idle_cyc", k, 44);
        chk("brst_bank_kept", ram_bank, 2'b00);
        chk("brst_log_n", nlog.size() - base, 20);
        repeat (4) step();
        chk("brst_no_stray_busy", busy, 1'b0);
        chk("brst_no_stray_csn", ram_csn, 1'b1);

        // Two-byte write DE AD at 0x000010.
        base = nlog.size();
        addr = 24'h000010; we = 1'b1; wdata = 8'hDE; stop = 1'b0; start = 1'b1;
        step(); start = 1'b0; k = 1; nv = 0;
        while (busy === 1'b1 && k < 100) begin
            if (wdata_ready === 1'b1 && nv < 4) begin v_cyc[nv] = k; nv++; end
            chk("wr_no_rvalid", rdata_valid, 1'b0);
            step(); k++;
            if (k == 17) wdata = 8'hAD;
            if (k == 22) stop = 1'b1;
        end
        we = 1'b0;
        chk("wr_ready_count", nv, 2);
        chk("wr_ready_cyc0", v_cyc[0], 16);
        chk("wr_ready_cyc1", v_cyc[1], 20);
        chk("wr_idle_cyc", k, 28);
        chk("wr_log_n", nlog.size() - base, 12);
        for (int i = 0; i < 12; i++)
            chk("wr_nibble", nlog[base + i], {4'b1111, exp_wr[i]});
        chk("wr_mem0", mem[8'h10], 8'hDE);
        chk("wr_mem1", mem[8'h11], 8'hAD);

        // Read on bank 2, aborted by reset while in RDATA.
        addr = 24'h000056; we = 1'b0; bank = 2'b10; stop = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        chk("bank2_sel", ram_bank, 2'b10);
        repeat (30) step();
        rst_n = 1'b0;
        #1;
        chk("abort_csn", ram_csn, 1'b1);
        chk("abort_oe", ram_io_oe, 4'h0);
        chk("abort_init_done", init_done, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_clk", ram_clk, 1'b0);
        chk("abort_bank", ram_bank, 2'b00);
        chk("abort_rdata", rdata, 8'h00);
        bank = 2'b00; stop = 1'b1;
        step(); step();
        rst_n = 1'b1;
        do_init(1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
